// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one Izhikevich update core across N_NEURONS neurons.
// Per-neuron state and config live here; the core is driven over a req/ack handshake.
module izh_neuron_scheduler #(
    parameter int unsigned  N_NEURONS = 4,
    parameter int unsigned  W         = 18,
    parameter logic [W-1:0] V_RST     = 18'sh3_4CCD,
    parameter logic [W-1:0] U_RST     = 18'sh3_CCCD,
    localparam int unsigned IW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_addr,
    input  logic                 cfg_sel,
    input  logic [7:0]           cfg_data,
    output logic                 dp_req,
    output logic [W-1:0]         dp_v,
    output logic [W-1:0]         dp_u,
    output logic [W-1:0]         dp_i,
    output logic [3:0]           dp_a,
    output logic [3:0]           dp_b,
    input  logic                 dp_ack,
    input  logic [W-1:0]         dp_v_nxt,
    input  logic [W-1:0]         dp_u_nxt,
    input  logic                 dp_spike,
    output logic                 spk_valid,
    output logic [IW-1:0]        spk_id,
    output logic [N_NEURONS-1:0] spk_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    input  logic [IW-1:0]        mon_addr,
    output logic [7:0]           mon_v
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StDone} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q;
    logic [W-1:0]         v_q [N_NEURONS];
    logic [W-1:0]         u_q [N_NEURONS];
    logic [7:0]           i_q [N_NEURONS];
    logic [3:0]           a_q [N_NEURONS];
    logic [3:0]           b_q [N_NEURONS];
    logic [W-1:0]         res_v_q, res_u_q;
    logic                 res_spk_q;
    logic                 dp_req_q;
    logic [W-1:0]         dp_v_q, dp_u_q, dp_i_q;
    logic [3:0]           dp_a_q, dp_b_q;
    logic [N_NEURONS-1:0] spk_vec_q;
    logic                 overrun_q;
    logic [7:0]           mon_v_q;
    logic [W-1:0]         mon_word;
    logic                 last_idx;
    logic                 cfg_hit;

    assign last_idx = (idx_q == IW'(N_NEURONS - 1));
    assign cfg_hit  = cfg_we && (32'(cfg_addr) < N_NEURONS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        spk_valid = 1'b0;
        spk_id    = '0;
        case (state_q)
            StIdle:  if (tick) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (dp_ack) state_d = StWb;
            StWb: begin
                spk_valid = res_spk_q;
                spk_id    = res_spk_q ? idx_q : '0;
                state_d   = last_idx ? StDone : StIssue;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A WB in flight for the monitored neuron is forwarded so mon_v never shows stale data.
    always_comb begin
        mon_word = '0;
        if (32'(mon_addr) < N_NEURONS) mon_word = v_q[mon_addr];
        if (state_q == StWb && mon_addr == idx_q) mon_word = res_v_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n] <= V_RST;
                u_q[n] <= U_RST;
                i_q[n] <= '0;
                a_q[n] <= '0;
                b_q[n] <= '0;
            end
            idx_q     <= '0;
            res_v_q   <= '0;
            res_u_q   <= '0;
            res_spk_q <= 1'b0;
            dp_req_q  <= 1'b0;
            dp_v_q    <= '0;
            dp_u_q    <= '0;
            dp_i_q    <= '0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            spk_vec_q <= '0;
            overrun_q <= 1'b0;
            mon_v_q   <= V_RST[W-1:W-8];
        end else begin
            if (cfg_hit) begin
                if (cfg_sel) begin
                    b_q[cfg_addr] <= cfg_data[7:4];
                    a_q[cfg_addr] <= cfg_data[3:0];
                end else begin
                    i_q[cfg_addr] <= cfg_data;
                end
            end
            if (tick && state_q != StIdle) overrun_q <= 1'b1;
            mon_v_q <= mon_word[W-1:W-8];

            case (state_q)
                StIdle: begin
                    if (tick) begin
                        idx_q     <= '0;
                        spk_vec_q <= '0;
                    end
                end
                StIssue: begin
                    dp_v_q   <= v_q[idx_q];
                    dp_u_q   <= u_q[idx_q];
                    dp_i_q   <= {i_q[idx_q], {(W-8){1'b0}}};
                    dp_a_q   <= a_q[idx_q];
                    dp_b_q   <= b_q[idx_q];
                    dp_req_q <= 1'b1;
                end
                StWait: begin
                    if (dp_ack) begin
                        res_v_q   <= dp_v_nxt;
                        res_u_q   <= dp_u_nxt;
                        res_spk_q <= dp_spike;
                        dp_req_q  <= 1'b0;
                    end
                end
                StWb: begin
                    v_q[idx_q] <= res_v_q;
                    u_q[idx_q] <= res_u_q;
                    if (res_spk_q) spk_vec_q[idx_q] <= 1'b1;
                    if (!last_idx) idx_q <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign dp_req  = dp_req_q;
    assign dp_v    = dp_v_q;
    assign dp_u    = dp_u_q;
    assign dp_i    = dp_i_q;
    assign dp_a    = dp_a_q;
    assign dp_b    = dp_b_q;
    assign spk_vec = spk_vec_q;
    assign overrun = overrun_q;
    assign mon_v   = mon_v_q;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Randomized self-checking bench for izh_neuron_scheduler; the bench plays the update core
// and tracks expected neuron state, config and spike bookkeeping in plain arrays.
module tb_izh_neuron_scheduler;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int IW = 2;
    localparam logic [W-1:0] V_RST = 18'h34CCD;
    localparam logic [W-1:0] U_RST = 18'h3CCCD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic          cfg_sel;
    logic [7:0]    cfg_data;
    logic          dp_req;
    logic [W-1:0]  dp_v, dp_u, dp_i;
    logic [3:0]    dp_a, dp_b;
    logic          dp_ack;
    logic [W-1:0]  dp_v_nxt, dp_u_nxt;
    logic          dp_spike;
    logic          spk_valid;
    logic [IW-1:0] spk_id;
    logic [N-1:0]  spk_vec;
    logic          busy, done, overrun;
    logic [IW-1:0] mon_addr;
    logic [7:0]    mon_v;

    always #5 clk = ~clk;

    izh_neuron_scheduler #(
        .N_NEURONS(N),
        .W        (W),
        .V_RST    (V_RST),
        .U_RST    (U_RST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .dp_req   (dp_req),
        .dp_v     (dp_v),
        .dp_u     (dp_u),
        .dp_i     (dp_i),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_ack   (dp_ack),
        .dp_v_nxt (dp_v_nxt),
        .dp_u_nxt (dp_u_nxt),
        .dp_spike (dp_spike),
        .spk_valid(spk_valid),
        .spk_id   (spk_id),
        .spk_vec  (spk_vec),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .mon_addr (mon_addr),
        .mon_v    (mon_v)
    );

    // Reference state
    logic [W-1:0] mv [N];
    logic [W-1:0] mu [N];
    logic [7:0]   mi [N];
    logic [3:0]   ma [N];
    logic [3:0]   mb [N];
    logic         exp_ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = V_RST;
            mu[n] = U_RST;
            mi[n] = '0;
            ma[n] = '0;
            mb[n] = '0;
        end
        exp_ovr = 1'b0;
    endfunction

    function automatic void model_cfg(input int addr, input logic sel, input logic [7:0] data);
        if (sel) begin
            mb[addr] = data[7:4];
            ma[addr] = data[3:0];
        end else begin
            mi[addr] = data;
        end
    endfunction

    task automatic cfg_write(input int addr, input logic sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_addr = IW'(addr);
        cfg_sel  = sel;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
        model_cfg(addr, sel, data);
    endtask

    task automatic mon_check();
        for (int n = 0; n < N; n++) begin
            mon_addr = IW'(n);
            step();
            check_eq("mon_v", mon_v, mv[n][W-1:W-8]);
        end
    endtask

    // One full sweep; the bench answers each request after ack_dly extra WAIT cycles.
    task automatic run_sweep(input int ack_dly, input logic [N-1:0] spk_mask, input bit ovr_tick,
                             input int abort_idx, input bit mid_cfg);
        logic [N-1:0] exp_vec;
        logic [61:0]  snap;
        logic [31:0]  r;
        logic [W-1:0] rv, ru;
        logic         sp;
        int           t0;
        int           guard;
        exp_vec = '0;
        t0 = cyc;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_eq("busy_start", busy, 1);
        check_eq("spk_vec_clr", spk_vec, 0);
        for (int n = 0; n < N; n++) begin
            guard = 0;
            while (dp_req !== 1'b1 && guard < 8) begin
                step();
                guard++;
            end
            check_eq("req_seen", dp_req, 1);
            if (dp_req !== 1'b1) return;
            check_eq("dp_v", dp_v, mv[n]);
            check_eq("dp_u", dp_u, mu[n]);
            check_eq("dp_i", dp_i, {mi[n], 10'h0});
            check_eq("dp_a", dp_a, ma[n]);
            check_eq("dp_b", dp_b, mb[n]);
            if (abort_idx == n) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check_eq("abort_req", dp_req, 0);
                check_eq("abort_busy", busy, 0);
                model_reset();
                return;
            end
            snap = {dp_v, dp_u, dp_i, dp_a, dp_b};
            mon_addr = IW'(n);
            if (ovr_tick && n == 0) begin
                tick = 1'b1;
                exp_ovr = 1'b1;
            end
            if (mid_cfg) begin
                r = $urandom;
                cfg_we   = 1'b1;
                cfg_addr = r[IW-1:0];
                cfg_sel  = r[8];
                cfg_data = r[23:16];
                model_cfg(int'(r[IW-1:0]), r[8], r[23:16]);
            end
            for (int k = 0; k < ack_dly; k++) begin
                step();
                tick   = 1'b0;
                cfg_we = 1'b0;
                check_eq("hold_req", dp_req, 1);
                check_eq("hold_ops", {dp_v, dp_u, dp_i, dp_a, dp_b}, snap);
            end
            r  = $urandom;
            rv = r[W-1:0];
            r  = $urandom;
            ru = r[W-1:0];
            sp = spk_mask[n];
            dp_ack   = 1'b1;
            dp_v_nxt = rv;
            dp_u_nxt = ru;
            dp_spike = sp;
            step();
            tick     = 1'b0;
            cfg_we   = 1'b0;
            dp_ack   = 1'b0;
            dp_spike = 1'b0;
            check_eq("wb_req_low", dp_req, 0);
            check_eq("spk_valid", spk_valid, sp);
            if (sp) check_eq("spk_id", spk_id, n);
            mv[n] = rv;
            mu[n] = ru;
            if (sp) exp_vec[n] = 1'b1;
            step();
            check_eq("spk_pulse", spk_valid, 0);
            check_eq("mon_fwd", mon_v, rv[W-1:W-8]);
            if (n == N - 1) begin
                check_eq("done", done, 1);
                check_eq("sweep_len", cyc - t0, 3 * N + 1 + N * ack_dly);
                check_eq("spk_vec", spk_vec, exp_vec);
                check_eq("overrun", overrun, exp_ovr);
                step();
                check_eq("done_pulse", done, 0);
                check_eq("busy_end", busy, 0);
            end else begin
                check_eq("mid_done", done, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  r;
        logic [N-1:0] msk;
        tick = 0; cfg_we = 0; cfg_addr = 0; cfg_sel = 0; cfg_data = 0;
        dp_ack = 0; dp_v_nxt = 0; dp_u_nxt = 0; dp_spike = 0; mon_addr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_spk_vec", spk_vec, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_dp_req", dp_req, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_spk_valid", spk_valid, 0);
        check_eq("rst_mon_v", mon_v, 8'hD3);
        mon_check();
        check_eq("rst_mon_d3", mon_v, 8'hD3);

        // Directed sweep: I[2]=0x40, spikes on neurons 1 and 3
        cfg_write(2, 1'b0, 8'h40);
        run_sweep(2, 4'b1010, 1'b0, -1, 1'b0);
        repeat (3) step();
        check_eq("spk_vec_hold", spk_vec, 4'b1010);
        check_eq("idle_busy", busy, 0);

        // Tick during WAIT of neuron 0
        r = $urandom;
        msk = r[N-1:0];
        run_sweep(1, msk, 1'b1, -1, 1'b0);
        check_eq("overrun_sticky", overrun, 1);

        // Long stall with a config write landing mid-sweep
        r = $urandom;
        msk = r[N-1:0];
        run_sweep(20, msk, 1'b0, -1, 1'b1);

        // Stray ack while idle
        dp_ack = 1'b1;
        r = $urandom;
        dp_v_nxt = r[W-1:0];
        dp_spike = 1'b1;
        repeat (3) begin
            step();
            check_eq("stray_busy", busy, 0);
            check_eq("stray_req", dp_req, 0);
            check_eq("stray_spk", spk_valid, 0);
        end
        dp_ack = 1'b0;
        dp_spike = 1'b0;
        mon_check();

        for (int s = 0; s < 4; s++) begin
            repeat (2) begin
                r = $urandom;
                cfg_write(int'(r[IW-1:0]), r[4], r[15:8]);
            end
            r = $urandom;
            run_sweep(int'(r[1:0]), r[N+7:8], 1'b0, -1, r[20]);
            mon_check();
        end

        // Reset during WAIT of neuron 2
        run_sweep(0, 4'b1111, 1'b0, 2, 1'b0);
        check_eq("post_rst_overrun", overrun, 0);
        check_eq("post_rst_spk_vec", spk_vec, 0);
        mon_check();
        for (int n = 0; n < N; n++) begin
            r = $urandom;
            cfg_write(n, 1'b0, {4'(n + 1), r[3:0]});
            cfg_write(n, 1'b1, r[15:8]);
        end
        r = $urandom;
        msk = r[N-1:0];
        run_sweep(0, msk, 1'b0, -1, 1'b0);
        mon_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
